// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed N-digit seven-segment scanner with active-low drive.
// New values are double-buffered and only become visible at a frame boundary.
module seven_seg_scan_controller #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter bit HEX_MODE      = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [NUM_DIGITS-1:0]   anode_out,
   output logic [6:0]              LED_out,
   output logic                    dp_out,
   output logic                    frame_tick
);

   localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              led_q, led_d;
   logic                    dp_q, dp_d;
   logic                    tick_q, tick_d;

   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zero_from;
   logic                    wrap;
   logic                    blank;

   // zero_from[k]: every active nibble from k up to the top digit is zero
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]       = act_val_q[4*gi +: 4];
      assign zero_from[gi] = (act_val_q[4*NUM_DIGITS-1:4*gi] == '0);
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = HEX_MODE ? 7'b0001000 : 7'b1111111;
         4'hB:    seg = HEX_MODE ? 7'b1100000 : 7'b1111111;
         4'hC:    seg = HEX_MODE ? 7'b0110001 : 7'b1111111;
         4'hD:    seg = HEX_MODE ? 7'b1000010 : 7'b1111111;
         4'hE:    seg = HEX_MODE ? 7'b0110000 : 7'b1111111;
         default: seg = HEX_MODE ? 7'b0111000 : 7'b1111111;
      endcase
      return seg;
   endfunction

   assign wrap  = enable && (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
   assign blank = BLANK_LEADING && (idx_q != '0) && zero_from[idx_q];

   always_comb begin
      presc_d      = presc_q;
      idx_d        = idx_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;
      act_val_d    = act_val_q;
      act_dp_d     = act_dp_q;
      anode_d      = '1;
      led_d        = '1;
      dp_d         = 1'b1;
      tick_d       = 1'b0;

      if (enable) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
         anode_d = ~(NUM_DIGITS'(1) << idx_q);
         led_d   = blank ? 7'b1111111 : seg_decode(nib[idx_q]);
         dp_d    = ~act_dp_q[idx_q];
         tick_d  = wrap;
      end else begin
         presc_d = '0;
         idx_d   = '0;
      end

      // Transfer happens before the load so a coincident load lands in pending
      if (wrap && pend_valid_q) begin
         act_val_d    = pend_val_q;
         act_dp_d     = pend_dp_q;
         pend_valid_d = 1'b0;
      end
      if (load) begin
         pend_val_d   = value_in;
         pend_dp_d    = dp_in;
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         anode_q      <= '1;
         led_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         tick_q       <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         anode_q      <= anode_d;
         led_q        <= led_d;
         dp_q         <= dp_d;
         tick_q       <= tick_d;
      end
   end

   assign anode_out  = anode_q;
   assign LED_out    = led_q;
   assign dp_out     = dp_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: stimulus pushes the expected digit stream, a monitor pops it
// each time the display moves to a new digit. Two instances differ only in HEX_MODE.
module tb_seven_seg_scan_controller;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  anode_out, anode_h0;
   logic [6:0]  LED_out, led_h0;
   logic        dp_out, dp_h0;
   logic        frame_tick, tick_h0;

   seven_seg_scan_controller #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b1), .BLANK_LEADING(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .value_in(value_in), .dp_in(dp_in),
      .anode_out(anode_out), .LED_out(LED_out), .dp_out(dp_out),
      .frame_tick(frame_tick)
   );

   seven_seg_scan_controller #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b0), .BLANK_LEADING(1'b1)
   ) dut_h0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .value_in(value_in), .dp_in(dp_in),
      .anode_out(anode_h0), .LED_out(led_h0), .dp_out(dp_h0),
      .frame_tick(tick_h0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         dig;
      logic [6:0] led1;
      logic [6:0] led0;
      logic       dpn;
   } item_t;

   item_t exp_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   logic [15:0] m_act_v, m_pend_v;
   logic [3:0]  m_act_d, m_pend_d;
   bit          m_pv;
   int          pos;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] n, input bit hex);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
         4'hA: s = hex ? 7'b0001000 : 7'b1111111;
         4'hB: s = hex ? 7'b1100000 : 7'b1111111;
         4'hC: s = hex ? 7'b0110001 : 7'b1111111;
         4'hD: s = hex ? 7'b1000010 : 7'b1111111;
         4'hE: s = hex ? 7'b0110000 : 7'b1111111;
         default: s = hex ? 7'b0111000 : 7'b1111111;
      endcase
      return s;
   endfunction

   task automatic push_exp(input int k);
      item_t it;
      logic [15:0] upper;
      logic [3:0]  nib;
      upper = m_act_v >> (4 * k);
      nib   = upper[3:0];
      it.dig = k;
      if (k > 0 && upper == 16'h0) begin
         it.led1 = 7'b1111111;
         it.led0 = 7'b1111111;
      end else begin
         it.led1 = seg(nib, 1'b1);
         it.led0 = seg(nib, 1'b0);
      end
      it.dpn = ~m_act_d[k];
      exp_q.push_back(it);
   endtask

   task automatic model_reset();
      m_act_v = '0; m_pend_v = '0; m_act_d = '0; m_pend_d = '0; m_pv = 1'b0; pos = 0;
   endtask

   // One clock of scanning; inputs set at the negedge before the sampling edge
   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
      if (pos % 4 == 0) push_exp(pos / 4);
      load = ld; value_in = v; dp_in = d;
      @(negedge clk);
      load = 1'b0;
      if (pos == 15 && m_pv) begin
         m_act_v = m_pend_v; m_act_d = m_pend_d; m_pv = 1'b0;
      end
      if (ld) begin
         m_pend_v = v; m_pend_d = d; m_pv = 1'b1;
      end
      pos = (pos + 1) % 16;
   endtask

   task automatic frame(input int la, input logic [15:0] va, input logic [3:0] da,
                        input int lb, input logic [15:0] vb, input logic [3:0] db);
      for (int c = 0; c < 16; c++) begin
         if (c == la)      step(1'b1, va, da);
         else if (c == lb) step(1'b1, vb, db);
         else              step(1'b0, 16'h0, 4'h0);
      end
   endtask

   // Monitor: pops one expectation whenever a new digit is lit
   initial begin : monitor
      item_t      it;
      int         cur;
      int         dwell;
      logic [3:0] prev_an;
      logic [3:0] oh;
      cur = -1; dwell = 0; prev_an = 4'hF;
      forever begin
         @(negedge clk);
         if (anode_out == 4'hF) begin
            chk("dark_led", {25'd0, LED_out}, 32'h7F);
            chk("dark_dp", {31'd0, dp_out}, 32'h1);
            chk("dark_anode_h0", {28'd0, anode_h0}, 32'hF);
            cur = -1; dwell = 0;
         end else if (anode_out != prev_an) begin
            if (cur >= 0) chk("dwell", dwell, 4);
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_digit actual anode=%b required=no new digit t=%0t", anode_out, $time);
               cur = -1;
            end else begin
               it = exp_q.pop_front();
               oh = 4'b0001 << it.dig;
               chk($sformatf("anode_d%0d", it.dig), {28'd0, anode_out}, {28'd0, ~oh});
               chk($sformatf("anode_h0_d%0d", it.dig), {28'd0, anode_h0}, {28'd0, ~oh});
               chk($sformatf("led_d%0d", it.dig), {25'd0, LED_out}, {25'd0, it.led1});
               chk($sformatf("led_h0_d%0d", it.dig), {25'd0, led_h0}, {25'd0, it.led0});
               chk($sformatf("dp_d%0d", it.dig), {31'd0, dp_out}, {31'd0, it.dpn});
               $display("digit %0d anode=%b led=%b led_h0=%b dp=%b t=%0t",
                        it.dig, anode_out, LED_out, led_h0, dp_out, $time);
               cur = it.dig;
            end
            dwell = 1;
         end else begin
            dwell++;
         end
         chk("frame_tick", {31'd0, frame_tick}, {31'd0, (cur == 3 && dwell == 4)});
         chk("frame_tick_h0", {31'd0, tick_h0}, {31'd0, (cur == 3 && dwell == 4)});
         prev_an = anode_out;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   initial begin : stimulus
      rst_n = 1'b1; enable = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_anode", {28'd0, anode_out}, 32'hF);
         chk("rst_led", {25'd0, LED_out}, 32'h7F);
         chk("rst_tick", {31'd0, frame_tick}, 32'h0);
      end
      rst_n = 1'b1;
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // shows 0
      frame(5, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);              // still 0
      frame(3, 16'h0007, 4'h0, -1, 16'h0, 4'h0);                 // 1234
      frame(8, 16'h0000, 4'h0, -1, 16'h0, 4'h0);                 // 0007
      frame(10, 16'h00AF, 4'h0, -1, 16'h0, 4'h0);                // 0000
      frame(2, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);               // 00AF
      frame(4, 16'h5678, 4'b0001, 15, 16'h9ABC, 4'b1000);        // 2222
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // 5678
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // 9ABC
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 4'h0);

      enable = 1'b0;
      @(negedge clk);
      chk("dis_anode", {28'd0, anode_out}, 32'hF);
      chk("dis_led", {25'd0, LED_out}, 32'h7F);
      chk("dis_dp", {31'd0, dp_out}, 32'h1);
      load = 1'b1; value_in = 16'h0042; dp_in = 4'b0001;
      @(negedge clk);
      load = 1'b0;
      m_pend_v = 16'h0042; m_pend_d = 4'b0001; m_pv = 1'b1;
      @(negedge clk);
      enable = 1'b1; pos = 0;
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // 9ABC again
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // 0042

      for (int i = 0; i < 10; i++) step(i == 3, 16'h8888, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("async_anode", {28'd0, anode_out}, 32'hF);
      chk("async_led", {25'd0, LED_out}, 32'h7F);
      chk("async_dp", {31'd0, dp_out}, 32'h1);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);                   // 0, pending gone

      enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
- Time-multiplexed N-digit seven-segment display controller.
- Takes a packed BCD/hex value and per-digit decimal points, and scans digits one at a time with active-low anodes and cathodes.
- Latched values are double-buffered and only take effect at frame boundaries, so the display never tears mid-scan.
- Sits between datapath/counter logic and board display pins; the successor to the single-digit combinational decoder.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit is lit (>=2).
- HEX_MODE, 1, 1 = codes 10-15 decode to A,b,C,d,E,F; 0 = codes 10-15 blank.
- BLANK_LEADING, 1, 1 = suppress leading zeros above digit 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = scanning; 0 = display dark, scan state cleared.
- load  input  1  one-cycle strobe; captures value_in/dp_in into the pending register.
- value_in  input  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant/rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- anode_out  output  NUM_DIGITS  active-low digit select, one-hot-low while scanning.
- LED_out  output  7  active-low cathodes, bit6..bit0 = a,b,c,d,e,f,g.
- dp_out  output  1  active-low decimal point.
- frame_tick  output  1  one-cycle pulse when the scan wraps from the last digit back to digit 0.

Behaviour:
- Reset (async assert, sync release internally not required):
  - prescaler=0, digit_idx=0, pending and active registers=0, pend_valid=0.
  - Outputs: anode_out all 1s, LED_out=7'b1111111, dp_out=1, frame_tick=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - At terminal count it returns to 0 and digit_idx advances.
  - digit_idx wraps NUM_DIGITS-1 -> 0; that wrap cycle asserts frame_tick for one cycle.
- Load:
  - load=1 captures value_in/dp_in into pending and sets pend_valid.
  - A later load before the frame boundary overwrites pending (last load wins).
- Frame boundary:
  - On the cycle digit_idx wraps to 0, if pend_valid then active<=pending and pend_valid clears.
  - load in that same cycle: the new data goes to pending and pend_valid stays 1; the previous pending data is what transfers to active.
  - The first frame after reset displays active=0.
- Outputs:
  - All outputs are registered from digit_idx and active, so the display follows digit_idx with 1 cycle of latency.
  - anode_out bit digit_idx=0, all other bits 1.
- Decode (active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - HEX_MODE=0: codes 10-15 give 1111111.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k is blanked (LED_out=1111111) if k>0 and active nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - The anode is still driven; dp_out is unaffected by blanking.
- dp_out = ~active_dp[digit_idx].
- enable=0:
  - Next edge: prescaler=0, digit_idx=0, outputs return to their reset values, frame_tick=0.
  - active, pending and pend_valid are held; load is still accepted.
  - On re-enable, scanning restarts at digit 0 with a full REFRESH_DIV dwell.
- Reset mid-frame: immediate dark outputs, and pending data is discarded.
- NUM_DIGITS=1: the digit index is constant 0, frame_tick pulses every REFRESH_DIV cycles, and blanking never applies.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, hold rst_n=0, then release with enable=1:
  - During reset, anode_out=1111, LED_out=1111111.
  - After release, anode_out steps 1110,1101,1011,0111 every 4 cycles, with a frame_tick pulse every 16 cycles.
- Load value_in=16'h1234, dp_in=4'b0100 mid-frame:
  - Display stays 0 until the next frame_tick.
  - Next frame: digit0 LED_out=1001100 ("4"), digit3 LED_out=1001111 ("1"), dp_out=0 only while anode_out=1011.
- Load 16'h0007 with BLANK_LEADING=1:
  - Digits 3..1 show LED_out=1111111 while their anodes are driven low.
  - Digit 0 shows 0001111.
  - Load 16'h0000: digit 0 shows 0000001.
- Load 16'h00AF:
  - HEX_MODE=1: digit1=0001000, digit0=0111000.
  - HEX_MODE=0: both digits blank.
- Two loads (16'h1111 then 16'h2222) within one frame -> the next frame shows all "2" (0010010).
- load coincident with frame_tick -> the previously pending value displays now, and the new value displays one frame later.
- enable=0 mid-scan -> anode_out=1111 on the next edge; re-enable restarts at anode_out=1110 with a full 4-cycle dwell.
- rst_n pulled low asynchronously mid-scan -> outputs go dark immediately.
